// File: rtl/ram_loader_pkg.sv
// Shared types and helpers for the SPI-driven RAM loader.
// Holds the command opcode and FSM state encodings plus the lane one-hot helper.
// Imported by ram_loader (top) and ram_loader_addr (address counter).
package ram_loader_pkg;

  // Upper nibble of a command byte.
  typedef enum logic [3:0] {
    OP_RUN  = 4'd0,
    OP_HALT = 4'd1,
    OP_ADDR = 4'd2,
    OP_WR   = 4'd3,
    OP_RD   = 4'd4
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    WRITE = 2'd2,
    READ  = 2'd3
  } state_t;

  // Widest lane vector the helper can produce (XLEN up to 512).
  localparam int unsigned MAX_LANES = 64;

  // One-hot lane select; callers truncate to their own lane count.
  function automatic logic [MAX_LANES-1:0] lane_onehot(input int unsigned lane);
    lane_onehot = {{(MAX_LANES-1){1'b0}}, 1'b1} << lane;
  endfunction

endpackage

// File: rtl/ram_loader_addr.sv
// Byte-address counter for the RAM loader.
// Ports: clk_i/rst_n_i; load_vld_i/load_idx_i/load_last_i/load_byte_i assemble a
// little-endian start address; inc_i steps by one with wrap; addr_o/lane_oh_o out.
module ram_loader_addr
  import ram_loader_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned REGION_BYTES = 65536,
  parameter int unsigned LANES        = XLEN / 8,
  parameter int unsigned LANE_W       = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_vld_i,
  input  logic [LANE_W-1:0] load_idx_i,
  input  logic              load_last_i,
  input  logic [7:0]        load_byte_i,
  input  logic              inc_i,
  output logic [XLEN-1:0]   addr_o,
  output logic [LANES-1:0]  lane_oh_o
);

  localparam logic [XLEN-1:0] WRAP_MASK = XLEN'(REGION_BYTES - 1);

  logic [XLEN-1:0]   addr_q, addr_d;
  // Address bytes collect here so an aborted load leaves the live address intact.
  logic [XLEN-1:0]   shadow_q, shadow_d;
  logic [XLEN-1:0]   loaded;
  logic [LANE_W-1:0] lane_idx;

  always_comb begin
    loaded = shadow_q;
    for (int k = 0; k < int'(LANES); k++) begin
      if (load_idx_i == LANE_W'(k)) begin
        loaded[8*k +: 8] = load_byte_i;
      end
    end

    shadow_d = shadow_q;
    addr_d   = addr_q;
    if (load_vld_i) begin
      shadow_d = loaded;
      if (load_last_i) begin
        addr_d = loaded & WRAP_MASK;
      end
    end else if (inc_i) begin
      addr_d = (addr_q + XLEN'(1)) & WRAP_MASK;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      addr_q   <= '0;
      shadow_q <= '0;
    end else begin
      addr_q   <= addr_d;
      shadow_q <= shadow_d;
    end
  end

  assign lane_idx  = (LANES > 1) ? addr_q[LANE_W-1:0] : '0;
  assign lane_oh_o = LANES'(lane_onehot(32'(lane_idx)));
  assign addr_o    = addr_q;

endmodule

// File: rtl/ram_loader.sv
// RAM loader: turns the SPI byte stream into region selects, address, byte strobes.
// Ports: clk_i/rst_n_i; dc_i/byte_vld_i/byte_data_i in; cpu_rst_n_o, rd_sel_o,
// wr_sel_o, rw_addr_o, wr_data_o, wr_byte_en_o, err_o out (all registered).
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned N_REGION     = 2,
  parameter int unsigned REGION_BYTES = 65536
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  dc_i,
  input  logic                  byte_vld_i,
  input  logic [7:0]            byte_data_i,
  output logic                  cpu_rst_n_o,
  output logic [N_REGION-1:0]   rd_sel_o,
  output logic [N_REGION-1:0]   wr_sel_o,
  output logic [XLEN-1:0]       rw_addr_o,
  output logic [XLEN-1:0]       wr_data_o,
  output logic [XLEN/8-1:0]     wr_byte_en_o,
  output logic                  err_o
);

  localparam int unsigned LANES  = XLEN / 8;
  localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

  state_t              state_q, state_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic [N_REGION-1:0] rd_sel_q, rd_sel_d;
  logic [N_REGION-1:0] wr_sel_q, wr_sel_d;
  logic                err_q, err_d;
  logic [LANE_W-1:0]   idx_q, idx_d;
  logic [LANES-1:0]    strb_q, strb_d;
  logic [XLEN-1:0]     wr_data_q, wr_data_d;
  logic                inc_pend_q, inc_pend_d;

  logic                cmd_vld, dat_vld, cmd_ok, region_ok, idx_last;
  logic [3:0]          op_nib, reg_nib;
  logic [N_REGION-1:0] reg_oh;
  logic                load_vld;
  logic [LANES-1:0]    lane_oh;

  assign cmd_vld   = byte_vld_i & ~dc_i;
  assign dat_vld   = byte_vld_i & dc_i;
  assign op_nib    = byte_data_i[7:4];
  assign reg_nib   = byte_data_i[3:0];
  assign region_ok = 32'(reg_nib) < N_REGION;
  assign reg_oh    = N_REGION'(1) << reg_nib;
  assign idx_last  = idx_q == LANE_W'(LANES - 1);

  // RUN/HALT ignore the low nibble; only region-addressed ops check it.
  always_comb begin
    case (op_nib)
      OP_RUN, OP_HALT:     cmd_ok = 1'b1;
      OP_ADDR, OP_WR, OP_RD: cmd_ok = region_ok;
      default:             cmd_ok = 1'b0;
    endcase
  end

  // State register plus all other flops.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      cpu_rst_n_q <= 1'b0;
      rd_sel_q    <= '0;
      wr_sel_q    <= '0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      strb_q      <= '0;
      wr_data_q   <= '0;
      inc_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      rd_sel_q    <= rd_sel_d;
      wr_sel_q    <= wr_sel_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      strb_q      <= strb_d;
      wr_data_q   <= wr_data_d;
      inc_pend_q  <= inc_pend_d;
    end
  end

  // Next state: any command aborts the current state.
  always_comb begin
    state_d = state_q;
    if (cmd_vld) begin
      if (!cmd_ok) begin
        state_d = IDLE;
      end else begin
        case (op_nib)
          OP_ADDR: state_d = ADDR;
          OP_WR:   state_d = WRITE;
          OP_RD:   state_d = READ;
          default: state_d = IDLE;
        endcase
      end
    end else if (dat_vld && state_q == ADDR && idx_last) begin
      state_d = IDLE;
    end
  end

  // Outputs and datapath.
  always_comb begin
    cpu_rst_n_d = cpu_rst_n_q;
    rd_sel_d    = rd_sel_q;
    wr_sel_d    = wr_sel_q;
    err_d       = err_q;
    idx_d       = idx_q;
    strb_d      = '0;
    wr_data_d   = wr_data_q;
    inc_pend_d  = 1'b0;
    load_vld    = 1'b0;

    if (cmd_vld) begin
      err_d = ~cmd_ok;
      if (!cmd_ok) begin
        rd_sel_d = '0;
        wr_sel_d = '0;
      end else begin
        case (op_nib)
          OP_RUN: begin
            cpu_rst_n_d = 1'b1;
            rd_sel_d    = '0;
            wr_sel_d    = '0;
          end
          OP_HALT: begin
            cpu_rst_n_d = 1'b0;
            rd_sel_d    = '0;
            wr_sel_d    = '0;
          end
          OP_ADDR: begin
            cpu_rst_n_d = 1'b0;
            idx_d       = '0;
          end
          OP_WR: begin
            cpu_rst_n_d = 1'b0;
            wr_sel_d    = reg_oh;
            rd_sel_d    = '0;
          end
          OP_RD: begin
            cpu_rst_n_d = 1'b0;
            rd_sel_d    = reg_oh;
            wr_sel_d    = '0;
          end
          default: ;
        endcase
      end
    end else if (dat_vld) begin
      case (state_q)
        ADDR: begin
          load_vld = 1'b1;
          idx_d    = idx_q + LANE_W'(1);
        end
        WRITE: begin
          // Strobe shows next cycle at the current address; the step follows it.
          strb_d     = lane_oh;
          wr_data_d  = {LANES{byte_data_i}};
          inc_pend_d = 1'b1;
        end
        READ: begin
          inc_pend_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  ram_loader_addr #(
    .XLEN         (XLEN),
    .REGION_BYTES (REGION_BYTES),
    .LANES        (LANES),
    .LANE_W       (LANE_W)
  ) u_addr (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .load_vld_i  (load_vld),
    .load_idx_i  (idx_q),
    .load_last_i (idx_last),
    .load_byte_i (byte_data_i),
    .inc_i       (inc_pend_q),
    .addr_o      (rw_addr_o),
    .lane_oh_o   (lane_oh)
  );

  assign cpu_rst_n_o = cpu_rst_n_q;
  assign rd_sel_o    = rd_sel_q;
  assign wr_sel_o    = wr_sel_q;
  assign wr_data_o   = wr_data_q;
  assign err_o       = err_q;
  // Masked by reset so a strobe already queued when reset arrives never reaches the RAM.
  assign wr_byte_en_o = rst_n_i ? strb_q : '0;

endmodule

// File: tb/tb_ram_loader.sv
module tb_ram_loader;

  localparam int XLEN         = 32;
  localparam int N_REGION     = 2;
  localparam int REGION_BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst_n, dc, byte_vld;
  logic [7:0]  byte_data;
  logic        cpu_rst_n, err;
  logic [1:0]  rd_sel, wr_sel;
  logic [31:0] rw_addr, wr_data;
  logic [3:0]  wr_en;

  always #5 clk = ~clk;

  ram_loader #(.XLEN(XLEN), .N_REGION(N_REGION), .REGION_BYTES(REGION_BYTES)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .dc_i         (dc),
    .byte_vld_i   (byte_vld),
    .byte_data_i  (byte_data),
    .cpu_rst_n_o  (cpu_rst_n),
    .rd_sel_o     (rd_sel),
    .wr_sel_o     (wr_sel),
    .rw_addr_o    (rw_addr),
    .wr_data_o    (wr_data),
    .wr_byte_en_o (wr_en),
    .err_o        (err)
  );

  typedef struct packed {
    logic [3:0]  en;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  sel;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_exp, mon_act;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: what the loader should look like after each accepted byte.
  logic [31:0] m_addr, m_val, m_wdata;
  int          m_mode;  // 0 idle, 1 collecting address, 2 writing, 3 reading
  int          m_idx;
  logic        m_cpu, m_err;
  logic [1:0]  m_rd, m_wr;

  task automatic model_reset();
    m_addr = 0; m_val = 0; m_wdata = 0; m_mode = 0; m_idx = 0;
    m_cpu = 0; m_err = 0; m_rd = 0; m_wr = 0;
  endtask

  task automatic model_apply(input logic d, input logic [7:0] b);
    int op, r;
    bit ok;
    if (!d) begin
      op = int'(b[7:4]);
      r  = int'(b[3:0]);
      ok = (op <= 1) || (op >= 2 && op <= 4 && r < N_REGION);
      m_err = !ok;
      if (!ok) begin
        m_rd = 0; m_wr = 0; m_mode = 0;
      end else begin
        case (op)
          0: begin m_cpu = 1; m_rd = 0; m_wr = 0; m_mode = 0; end
          1: begin m_cpu = 0; m_rd = 0; m_wr = 0; m_mode = 0; end
          2: begin m_cpu = 0; m_mode = 1; m_idx = 0; m_val = 0; end
          3: begin m_cpu = 0; m_wr = 2'(1 << r); m_rd = 0; m_mode = 2; end
          default: begin m_cpu = 0; m_rd = 2'(1 << r); m_wr = 0; m_mode = 3; end
        endcase
      end
    end else begin
      case (m_mode)
        1: begin
          m_val[8*m_idx +: 8] = b;
          m_idx++;
          if (m_idx == XLEN / 8) begin
            m_addr = m_val % REGION_BYTES;
            m_mode = 0;
          end
        end
        2: begin
          m_wdata = {4{b}};
          exp_q.push_back('{en: 4'(1 << (m_addr % 4)), addr: m_addr, data: m_wdata, sel: m_wr});
          m_addr = (m_addr + 1) % REGION_BYTES;
        end
        3: m_addr = (m_addr + 1) % REGION_BYTES;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_state();
    chk("cpu_rst_n", 32'(cpu_rst_n), 32'(m_cpu));
    chk("rd_sel",    32'(rd_sel),    32'(m_rd));
    chk("wr_sel",    32'(wr_sel),    32'(m_wr));
    chk("rw_addr",   rw_addr,        m_addr);
    chk("wr_data",   wr_data,        m_wdata);
    chk("err",       32'(err),       32'(m_err));
    chk("idle_strobe", 32'(wr_en),   32'd0);
  endtask

  // One byte, then a random idle gap; state checked once everything has settled.
  task automatic send(input logic d, input logic [7:0] b);
    @(posedge clk); #1;
    dc = d; byte_data = b; byte_vld = 1'b1;
    model_apply(d, b);
    @(posedge clk); #1;
    byte_vld = 1'b0; dc = 1'($urandom); byte_data = 8'($urandom);
    repeat ($urandom_range(1, 3)) @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  // Scoreboard monitor: every strobe cycle must match the oldest expected write.
  always @(negedge clk) begin
    if (wr_en !== 4'b0000) begin
      checks++;
      mon_act = '{en: wr_en, addr: rw_addr, data: wr_data, sel: wr_sel};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL strobe_unexpected actual en=%b addr=%h data=%h sel=%b expected no strobe",
                 wr_en, rw_addr, wr_data, wr_sel);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          failures++;
          $display("FAIL strobe actual en=%b addr=%h data=%h sel=%b expected en=%b addr=%h data=%h sel=%b",
                   mon_act.en, mon_act.addr, mon_act.data, mon_act.sel,
                   mon_exp.en, mon_exp.addr, mon_exp.data, mon_exp.sel);
        end
      end
    end
  end

  initial begin
    int op, r;
    rst_n = 1'b0; dc = 1'b0; byte_vld = 1'b0; byte_data = 8'h00;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Release CPU.
    send(0, 8'h01);

    // Address 0x10, two writes into region 0.
    send(0, 8'h20);
    send(1, 8'h10); send(1, 8'h00); send(1, 8'h00); send(1, 8'h00);
    send(0, 8'h30);
    send(1, 8'hAA); send(1, 8'hBB);

    // Writes straddling the region wrap, region 1.
    send(0, 8'h20);
    send(1, 8'hFF); send(1, 8'hFF); send(1, 8'h00); send(1, 8'h00);
    send(0, 8'h31);
    send(1, 8'h5C); send(1, 8'hC5);

    // Read continues from current address without new SET_ADDR.
    send(0, 8'h41);
    send(1, 8'h01); send(1, 8'h02); send(1, 8'h03);

    // Bad region then valid command clears the error.
    send(0, 8'h35);
    send(0, 8'h01);

    // Reset one cycle after a write byte: the strobe must not appear.
    send(0, 8'h30);
    @(posedge clk); #1;
    dc = 1'b1; byte_data = 8'h5A; byte_vld = 1'b1;
    @(posedge clk); #1;
    byte_vld = 1'b0; rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    check_state();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 99) < 25) begin
        op = $urandom_range(0, 6);
        r  = (op <= 1) ? $urandom_range(0, N_REGION - 1) : $urandom_range(0, 3);
        send(0, {4'(op), 4'(r)});
      end else begin
        send(1, 8'($urandom));
      end
    end

    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
